// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: sizes, FSM states, scan classes.
package keypad_scanner_pkg;

    localparam int unsigned KEY_CODE_W = 4;
    localparam int unsigned NUM_ROWS   = 4;
    localparam int unsigned NUM_COLS   = 4;
    localparam int unsigned NUM_KEYS   = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } kp_state_e;

    typedef enum logic [1:0] {
        ScanEmpty,
        ScanSingle,
        ScanMulti
    } scan_class_e;

    // Classify a full-scan hit map (bit r*NUM_COLS+c set = key (r,c) down).
    function automatic scan_class_e scan_classify(input logic [NUM_KEYS-1:0] hits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (hits[i]) n++;
        end
        if (n == 0) return ScanEmpty;
        if (n == 1) return ScanSingle;
        return ScanMulti;
    endfunction

    // Code of a set bit in the hit map; only meaningful for a single hit.
    function automatic logic [KEY_CODE_W-1:0] scan_code(input logic [NUM_KEYS-1:0] hits);
        logic [KEY_CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (hits[i]) code = KEY_CODE_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs (idle level is all-ones).
module keypad_row_sync
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned WIDTH = NUM_ROWS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Shift the raw rows through two stages.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    // Synchronizer flops, released to the rows' idle (pulled-up) level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: one-cold column drive, per-scan classification and a
// press/release debounce FSM producing a one-cycle key_valid pulse per accepted press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 5000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_ROWS-1:0]   row_in,
    output logic [NUM_COLS-1:0]   col_out,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_down
);

    localparam int unsigned   DivW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]    DebTarget = 4'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] row_s;

    keypad_row_sync #(
        .WIDTH (NUM_ROWS)
    ) u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (row_in),
        .sync_o  (row_s)
    );

    logic [DivW-1:0]       div_q, div_d;
    logic [1:0]            col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0]   col_out_q, col_out_d;
    logic [NUM_KEYS-1:0]   hits_q, hits_d;
    logic [NUM_KEYS-1:0]   col_hits, scan_hits;
    logic                  sample_en, scan_done;
    scan_class_e           scan_cls;
    logic [KEY_CODE_W-1:0] scan_key;

    // Dwell counter, column stepping and per-column accumulation of the row samples.
    always_comb begin
        sample_en = (div_q == DivLast);
        scan_done = sample_en && (col_idx_q == 2'd3);
        div_d     = sample_en ? '0 : div_q + DivW'(1);
        col_idx_d = sample_en ? col_idx_q + 2'd1 : col_idx_q;
        // Registered copy of the decoded column so col_out has no decode glitches.
        col_out_d = ~(4'b0001 << col_idx_d);
        col_hits  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (2'(c) == col_idx_q) col_hits[r * NUM_COLS + c] = ~row_s[r];
            end
        end
        // Include the column being sampled now so the scan is judged on its last sample.
        scan_hits = hits_q | col_hits;
        hits_d    = hits_q;
        if (sample_en) hits_d = scan_done ? '0 : scan_hits;
        scan_cls  = scan_classify(scan_hits);
        scan_key  = scan_code(scan_hits);
    end

    kp_state_e             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d, cnt_inc;
    logic [KEY_CODE_W-1:0] cand_q, cand_d;
    logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  key_down_q, key_down_d;
    logic                  accept;

    // Debounce FSM next state; only a completed scan can move it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        accept      = 1'b0;
        cnt_inc     = cnt_q + 4'd1;
        if (scan_done) begin
            unique case (state_q)
                StIdle: begin
                    if (scan_cls == ScanSingle) begin
                        cand_d = scan_key;
                        cnt_d  = 4'd1;
                        if (DebTarget == 4'd1) accept = 1'b1;
                        else                   state_d = StPressWait;
                    end
                end
                StPressWait: begin
                    if (scan_cls == ScanSingle) begin
                        if (scan_key == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == DebTarget) accept = 1'b1;
                        end else begin
                            cand_d = scan_key;
                            cnt_d  = 4'd1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
                StPressed: begin
                    if (scan_cls == ScanEmpty) begin
                        cnt_d = 4'd1;
                        if (DebTarget == 4'd1) begin
                            key_down_d = 1'b0;
                            state_d    = StIdle;
                        end else begin
                            state_d = StReleaseWait;
                        end
                    end
                end
                StReleaseWait: begin
                    if (scan_cls == ScanEmpty) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebTarget) begin
                            key_down_d = 1'b0;
                            state_d    = StIdle;
                        end
                    end else begin
                        state_d = StPressed;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (accept) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = StPressed;
        end
    end

    // All scanner and FSM state, including the registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            hits_q      <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            hits_q      <= hits_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a directed scan table, a hand-written mid-press reset
// sequence, and randomized key patterns checked against a scan-level reference model.
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned DEB      = 3;
    localparam int          SCAN_CYC = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [15:0] keys;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r * 4 + c] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference model: a press is accepted when, while no key is down, the last DEB
    // scans all saw the same single key; a release when the last DEB scans were empty.
    int         m_run;
    int         m_last;
    logic       m_down;
    logic [3:0] m_code;

    function automatic int scan_value(input logic [15:0] k);
        int n;
        int idx;
        n   = 0;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                n++;
                idx = i;
            end
        end
        if (n == 0) return -1;
        if (n == 1) return idx;
        return 16;
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_last = -2;
        m_down = 1'b0;
        m_code = 4'd0;
    endtask

    task automatic model_scan(input logic [15:0] k, output logic v, output logic d,
                              output logic [3:0] code);
        int val;
        val = scan_value(k);
        if (val == m_last) m_run++;
        else begin
            m_run  = 1;
            m_last = val;
        end
        v = 1'b0;
        if (!m_down && val >= 0 && val < 16 && m_run == int'(DEB)) begin
            v      = 1'b1;
            m_down = 1'b1;
            m_code = 4'(val);
        end else if (m_down && val == -1 && m_run == int'(DEB)) begin
            m_down = 1'b0;
        end
        d    = m_down;
        code = m_code;
    endtask

    // Pulse reset for one cycle from just after an edge; release lands on a dwell start.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, " rst col_out"},   16'(col_out),   16'hE);
        check({tag, " rst key_code"},  16'(key_code),  16'h0);
        check({tag, " rst key_valid"}, 16'(key_valid), 16'h0);
        check({tag, " rst key_down"},  16'(key_down),  16'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // Hold a key pattern for one full scan; compare outputs after its evaluation edge.
    task automatic run_scan(input logic [15:0] k, input logic ev, input logic ed,
                            input logic [3:0] ec, input string tag);
        logic       col_ok;
        logic       stray;
        logic [3:0] exp_col;
        int         ci;
        col_ok = 1'b1;
        stray  = 1'b0;
        keys   = k;
        for (int i = 1; i <= SCAN_CYC; i++) begin
            @(posedge clk);
            #1;
            ci          = (i / int'(SCAN_DIV)) % 4;
            exp_col     = 4'hF;
            exp_col[ci] = 1'b0;
            if (col_out !== exp_col) col_ok = 1'b0;
            if (i < SCAN_CYC && key_valid !== 1'b0) stray = 1'b1;
        end
        check({tag, " col_out sequence ok"}, 16'(col_ok), 16'h1);
        check({tag, " stray key_valid"},     16'(stray),  16'h0);
        check({tag, " key_valid"},           16'(key_valid), 16'(ev));
        check({tag, " key_down"},            16'(key_down),  16'(ed));
        check({tag, " key_code"},            16'(key_code),  16'(ec));
    endtask

    typedef struct {
        logic [15:0] keys;
        logic        v;
        logic        d;
        logic [3:0]  code;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] k, input logic v, input logic d,
                       input logic [3:0] code, input int n);
        vec_t e;
        e.keys = k;
        e.v    = v;
        e.d    = d;
        e.code = code;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K1  = 16'h0002;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K11 = 16'h0800;
    localparam logic [15:0] K15 = 16'h8000;

    initial begin
        logic       ev, ed;
        logic [3:0] ec;
        logic [15:0] pat;
        int         sel, len, a, b;

        keys    = 16'h0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset("init");

        // Idle (7 scans > 200 cycles).
        add(16'h0, 0, 0, 4'd0, 7);
        // Hold (1,2) for 6 scans, then release.
        add(K6, 0, 0, 4'd0, 2);
        add(K6, 1, 1, 4'd6, 1);
        add(K6, 0, 1, 4'd6, 3);
        add(16'h0, 0, 1, 4'd6, 2);
        add(16'h0, 0, 0, 4'd6, 2);
        // Bounce: two scans only.
        add(K6, 0, 0, 4'd6, 2);
        add(16'h0, 0, 0, 4'd6, 2);
        // Two keys together.
        add(K0 | K15, 0, 0, 4'd6, 6);
        add(16'h0, 0, 0, 4'd6, 1);
        // Rollover: (0,1) accepted, then (2,3) slid in without a release.
        add(K1, 0, 0, 4'd6, 2);
        add(K1, 1, 1, 4'd1, 1);
        add(K1 | K11, 0, 1, 4'd1, 1);
        add(K11, 0, 1, 4'd1, 4);
        add(16'h0, 0, 1, 4'd1, 2);
        add(16'h0, 0, 0, 4'd1, 1);
        add(K11, 0, 0, 4'd1, 2);
        add(K11, 1, 1, 4'd11, 1);
        add(16'h0, 0, 1, 4'd11, 2);
        add(16'h0, 0, 0, 4'd11, 1);
        // Press (1,2) ahead of the reset sequence.
        add(K6, 0, 0, 4'd11, 2);
        add(K6, 1, 1, 4'd6, 1);
        add(K6, 0, 1, 4'd6, 1);

        foreach (tbl[i]) begin
            run_scan(tbl[i].keys, tbl[i].v, tbl[i].d, tbl[i].code, $sformatf("vec%0d", i));
        end

        // Reset while PRESSED with the key still held: fresh pulse after DEB scans.
        do_reset("midpress");
        run_scan(K6, 0, 0, 4'd0, "rst_hold1");
        run_scan(K6, 0, 0, 4'd0, "rst_hold2");
        run_scan(K6, 1, 1, 4'd6, "rst_hold3");
        run_scan(K6, 0, 1, 4'd6, "rst_hold4");
        run_scan(16'h0, 0, 1, 4'd6, "rst_rel1");
        run_scan(16'h0, 0, 1, 4'd6, "rst_rel2");
        run_scan(16'h0, 0, 0, 4'd6, "rst_rel3");

        // Randomized runs of key patterns against the reference model.
        keys = 16'h0;
        do_reset("rnd");
        for (int s = 0; s < 30; s++) begin
            sel = $urandom_range(0, 3);
            len = $urandom_range(1, 5);
            a   = $urandom_range(0, 15);
            b   = (a + $urandom_range(1, 15)) % 16;
            pat = 16'h0;
            if (sel == 1 || sel == 2) pat[a] = 1'b1;
            else if (sel == 3) begin
                pat[a] = 1'b1;
                pat[b] = 1'b1;
            end
            for (int j = 0; j < len; j++) begin
                model_scan(pat, ev, ed, ec);
                run_scan(pat, ev, ed, ec, $sformatf("rnd%0d.%0d", s, j));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 passive key matrix by driving one column low at a time and sampling the rows. Debounces the result over several full scans and emits one pulse per debounced key press with a 4-bit key code. It is the input-side counterpart of the multiplexed segment display driver: it produces the digit values the clock/settings logic loads into the display. It sits between the board key pins and the time-setting control logic.

## Interface
- SCAN_DIV, 5000: clock cycles each column stays driven (dwell); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; range 1..15.
- clk  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low.
- row_in  input  4  matrix rows, active-low (board pull-ups); asynchronous to clk.
- col_out  output  4  column drive, active-low one-cold; bit c low drives column c.
- key_code  output  4  code of last accepted key, {row[1:0], col[1:0]}; holds until next accepted press.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_down  output  1  high from the accepted press until the accepted release.

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Dwell counter counts 0..SCAN_DIV-1. Column index 0..3 advances when the counter wraps, and 3 wraps to 0. col_out = ~(1 << col_idx).
- Row sample is taken when the dwell counter equals SCAN_DIV-1. It is per-column accumulated into a scan result.
- Scan result classes, evaluated at the end of column 3:
  - EMPTY: no low row bit in any column.
  - SINGLE(code): exactly one low bit across all 16 positions.
  - MULTI: more than one low bit.
- Debounce FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. The 4-bit scan counter is cnt, and cand is the candidate code.
  - IDLE: on SINGLE(k), cand=k and cnt=1. If DEBOUNCE_SCANS==1, accept immediately; otherwise go to PRESS_WAIT. EMPTY and MULTI stay in IDLE.
  - PRESS_WAIT: on SINGLE(cand), cnt++. When cnt reaches DEBOUNCE_SCANS, accept.
    - On SINGLE(other), set cand=other and cnt=1.
    - On EMPTY or MULTI, go to IDLE.
  - Accept: key_code<=cand, pulse key_valid, key_down<=1, then go to PRESSED.
  - PRESSED: on EMPTY, cnt=1 and go to RELEASE_WAIT. Release needs only one empty scan when DEBOUNCE_SCANS==1. Any non-empty result stays in PRESSED.
  - RELEASE_WAIT: on EMPTY, cnt++. When cnt reaches DEBOUNCE_SCANS, key_down<=0 and go to IDLE. Any non-empty result returns to PRESSED.
- Rollover is not supported. A different key pressed while one is held produces no pulse until a full release has been accepted.

## Timing
- Reset values, held while reset_n is low:
  - col_out=4'b1110, key_code=0, key_valid=0, key_down=0.
  - state=IDLE, counters=0, synchronizer flops=4'b1111.
- reset_n assertion takes effect immediately (async). Deassertion is used as-is; the board supplies a synchronized deassertion.
- The scan period is 4*SCAN_DIV cycles. Scan results are evaluated on the cycle the column-3 sample is taken.
- key_valid rises on the clock edge after the DEBOUNCE_SCANS-th matching scan evaluation. key_code and key_down update on that same edge.
- Minimum press-to-pulse latency is DEBOUNCE_SCANS*4*SCAN_DIV cycles plus up to one scan of alignment plus 2 sync cycles.
- key_valid is never high on two consecutive cycles.
- All outputs are registered. No combinational path runs from row_in to any output.

## Structure
- Shared package:
  - KEY_CODE_W=4, NUM_ROWS=4, NUM_COLS=4.
  - FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Scan result class enum (EMPTY, SINGLE, MULTI).
- One sub-module: keypad_row_sync, a 4-bit 2-flop synchronizer with reset to all-ones.
- Scan sequencing and the debounce FSM stay in keypad_scanner.

## Test plan
Bench keypad model: row_in[r]=0 iff key (r,c) is pressed and col_out[c]==0. Parameters: SCAN_DIV=8, DEBOUNCE_SCANS=3.
- Reset, then idle for 200 cycles. col_out cycles 1110→1101→1011→0111 every 8 cycles. key_valid and key_down stay 0.
- Hold key (row1,col2) for 6 scans, then release. Expect:
  - exactly one key_valid pulse, with key_code=4'd6;
  - key_down high from that pulse;
  - key_down low after 3 consecutive empty scans.
- Hold (row1,col2) for 2 scans only, then release (bounce). No key_valid, and key_down stays 0.
- Hold (0,0) and (3,3) together for 6 scans. All scans classify MULTI, with no key_valid and key_code unchanged.
- Hold (0,1) until accepted, then add (2,3) and drop (0,1) without releasing. No second pulse. After a full release and a new press of (2,3), one pulse with key_code=4'd11.
- Drive reset_n low mid-PRESSED for one cycle. Outputs go to reset values asynchronously. Keeping the key held then yields a fresh pulse after 3 scans.
